// File: rtl/circuit1_pkg.sv
// Shared types and constants for the circuit1 scheduled datapath.
// CIRCUIT1_CTRL_DUAL_ADD_EN selects the dual-adder schedule (3-edge latency).
package circuit1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD_D,
    ADD_E,
    ADD,
    CMP_MUL,
    SUB
  } state_t;

`ifdef CIRCUIT1_CTRL_DUAL_ADD_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 4;
`endif

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/circuit1_ctrl_if.sv
// Start/done job handshake between a host sequencer and circuit1_ctrl.
interface circuit1_ctrl_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           busy;
  logic           done;
  logic [W-1:0]   z;
  logic [2*W-1:0] x;

  modport master (output start, a, b, c, input busy, done, z, x);
  modport slave  (input start, a, b, c, output busy, done, z, x);
endinterface

// File: rtl/circuit1_addsub.sv
// Shared 2W-wide add/sub unit; purely combinational, wraps modulo 2^(2W).
module circuit1_addsub
  import circuit1_pkg::*;
#(
  parameter int W2 = 16
) (
  input  logic          op,
  input  logic [W2-1:0] lhs,
  input  logic [W2-1:0] rhs,
  output logic [W2-1:0] res
);

  assign res = (op == OP_SUB) ? (lhs - rhs) : (lhs + rhs);

endmodule

// File: rtl/comparator.sv
// Unsigned greater-than comparator at DATAWIDTH.
module comparator #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 gt
);

  assign gt = (a > b);

endmodule

// File: rtl/multiplier.sv
// Unsigned DATAWIDTH x DATAWIDTH multiplier with full 2*DATAWIDTH product.
module multiplier #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0]   a,
  input  logic [DATAWIDTH-1:0]   b,
  output logic [2*DATAWIDTH-1:0] prod
);

  assign prod = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};

endmodule

// File: rtl/circuit1_ctrl.sv
// Multi-cycle circuit1: z = max(a+b, a+c), x = a*c - (a+b), behind start/done.
// Define CIRCUIT1_CTRL_DUAL_ADD_EN to compute both sums in one state.
module circuit1_ctrl
  import circuit1_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  circuit1_ctrl_if.slave  bus
);

  localparam int W = DATAWIDTH;

  state_t         state_reg;
  logic [W-1:0]   a_reg, b_reg, c_reg;
  logic [W-1:0]   d_reg, e_reg;
  logic [2*W-1:0] f_reg;
  logic           g_reg;
  logic           busy_reg, done_reg;
  logic [W-1:0]   z_reg;
  logic [2*W-1:0] x_reg;

  logic           as_op;
  logic [2*W-1:0] as_lhs, as_rhs, as_res;
  logic [2*W-1:0] prod;
  logic           d_gt_e;

  // Adds feed zero-extended operands and keep only the low W bits of the sum.
  always_comb begin
    as_op  = OP_ADD;
    as_lhs = {{W{1'b0}}, a_reg};
    as_rhs = {{W{1'b0}}, b_reg};
    case (state_reg)
      ADD_E: as_rhs = {{W{1'b0}}, c_reg};
      SUB: begin
        as_op  = OP_SUB;
        as_lhs = f_reg;
        as_rhs = {{W{1'b0}}, d_reg};
      end
      default: ;
    endcase
  end

  circuit1_addsub #(.W2(2*W)) u_addsub (
    .op  (as_op),
    .lhs (as_lhs),
    .rhs (as_rhs),
    .res (as_res)
  );

  multiplier #(.DATAWIDTH(W)) u_mul (
    .a    (a_reg),
    .b    (c_reg),
    .prod (prod)
  );

  comparator #(.DATAWIDTH(W)) u_cmp (
    .a  (d_reg),
    .b  (e_reg),
    .gt (d_gt_e)
  );

`ifdef CIRCUIT1_CTRL_DUAL_ADD_EN
  logic [W-1:0] e_sum;
  assign e_sum = a_reg + c_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      e_reg     <= '0;
      f_reg     <= '0;
      g_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      z_reg     <= '0;
      x_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            c_reg    <= bus.c;
            busy_reg <= 1'b1;
`ifdef CIRCUIT1_CTRL_DUAL_ADD_EN
            state_reg <= ADD;
`else
            state_reg <= ADD_D;
`endif
          end
        end
`ifdef CIRCUIT1_CTRL_DUAL_ADD_EN
        ADD: begin
          d_reg     <= as_res[W-1:0];
          e_reg     <= e_sum;
          state_reg <= CMP_MUL;
        end
`else
        ADD_D: begin
          d_reg     <= as_res[W-1:0];
          state_reg <= ADD_E;
        end
        ADD_E: begin
          e_reg     <= as_res[W-1:0];
          state_reg <= CMP_MUL;
        end
`endif
        CMP_MUL: begin
          f_reg     <= prod;
          g_reg     <= d_gt_e;
          state_reg <= SUB;
        end
        SUB: begin
          x_reg     <= as_res;
          z_reg     <= g_reg ? d_reg : e_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.z    = z_reg;
  assign bus.x    = x_reg;

endmodule

// File: tb/tb_circuit1_ctrl.sv
// Self-checking bench for circuit1_ctrl: job-level reference model plus directed
// and randomized start/operand/reset stimulus.
module tb_circuit1_ctrl;
  import circuit1_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  circuit1_ctrl_if #(.W(W)) bus ();
  circuit1_ctrl #(.DATAWIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the defining equations.
  function automatic logic [W-1:0] ref_z(input int a, input int b, input int c);
    int d, e;
    d = (a + b) % 256;
    e = (a + c) % 256;
    return W'((d > e) ? d : e);
  endfunction

  function automatic logic [2*W-1:0] ref_x(input int a, input int b, input int c);
    int d, f;
    d = (a + b) % 256;
    f = a * c;
    return (2*W)'((f - d + 65536) % 65536);
  endfunction

  // Job-level model: remaining cycles of the in-flight job, results on completion.
  int             m_rem = 0;
  logic           m_done = 1'b0;
  logic [W-1:0]   m_z = '0;
  logic [2*W-1:0] m_x = '0;
  int             ja = 0, jb = 0, jc = 0;
  int             dut_dones = 0, model_dones = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_z    = '0;
      m_x    = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem == 0) begin
        if (bus.start) begin
          ja = int'(bus.a);
          jb = int'(bus.b);
          jc = int'(bus.c);
          m_rem = LATENCY;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_z = ref_z(ja, jb, jc);
          m_x = ref_x(ja, jb, jc);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_rem > 0));
    check("done", 32'(bus.done), 32'(m_done));
    check("z", 32'(bus.z), 32'(m_z));
    check("x", 32'(bus.x), 32'(m_x));
    if (bus.done) dut_dones++;
    if (m_done) model_dones++;
  end

  task automatic run_job(input int a, input int b, input int c,
                         input int ez, input int ex, input string tag);
    int  edges, busy_cycles;
    bit  seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = W'(a); bus.b = W'(b); bus.c = W'(c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
    edges = 0; busy_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, edges, LATENCY);
    check({tag, " busy cycles"}, busy_cycles, LATENCY);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check({tag, " z"}, 32'(bus.z), ez);
    check({tag, " x"}, 32'(bus.x), ex);
  endtask

  initial begin
    int  d0, edges;
    bit  seen;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;

    check("model z 3,4,5", 32'(ref_z(3, 4, 5)), 32'd8);
    check("model x 10,20,2", 32'(ref_x(10, 20, 2)), 32'hFFF6);
    check("model x 200,100,255", 32'(ref_x(200, 100, 255)), 32'hC70C);

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset z", 32'(bus.z), 32'd0);
    check("reset x", 32'(bus.x), 32'd0);
    rst = 1'b1;

    run_job(3, 4, 5, 8, 16'h0008, "job 3,4,5");
    run_job(10, 20, 2, 30, 16'hFFF6, "job 10,20,2");
    run_job(200, 100, 255, 199, 16'hC70C, "job 200,100,255");

    // start held high through a job, then a new job accepted from the done cycle
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd5;
    @(posedge clk); #1;
    d0 = dut_dones;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
    end
    check("held start done seen", 32'(seen), 32'd1);
    check("held start z", 32'(bus.z), 32'd8);
    check("held start x", 32'(bus.x), 32'h0008);
    bus.a = 8'd1; bus.b = 8'd1; bus.c = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) seen = 1'b1;
    end
    check("b2b done seen", 32'(seen), 32'd1);
    check("b2b latency", edges, LATENCY);
    check("b2b z", 32'(bus.z), 32'd2);
    check("b2b x", 32'(bus.x), 32'hFFFF);
    @(negedge clk); #1;
    check("held start done count", dut_dones - d0, 2);

    // reset while the job is in the multiply/compare state
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (LATENCY - 2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midjob rst busy", 32'(bus.busy), 32'd0);
    check("midjob rst done", 32'(bus.done), 32'd0);
    check("midjob rst z", 32'(bus.z), 32'd0);
    check("midjob rst x", 32'(bus.x), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    d0 = dut_dones;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check("no done after abort", dut_dones - d0, 0);
    run_job(3, 4, 5, 8, 16'h0008, "job after reset");

    // randomized starts, operands and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) != 0);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check("total done count", dut_dones, model_dones);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
